// File: rtl/host_adapter_bus_interface_if.sv
// BBC-side strobe/data bus and SCSI bus bundle for the host adapter register stage.
// The slave modport is the adapter itself; master is the host/bus-model side.
interface host_adapter_bus_interface_if;
    logic       nFC40RD;
    logic       nFC41RD;
    logic       nFC40WR;
    logic       nFC42WR;
    logic       nFC43WR;
    logic       nFC44WR;
    logic [7:0] bbc_DATA_in;
    logic [7:0] bbc_DATA_out;
    logic       bbc_DATA_oe;
    logic       nIRQ;

    logic       scsi_nBSY;
    logic       scsi_nREQ;
    logic       scsi_nMSG;
    logic       scsi_nCD;
    logic       scsi_nIO;
    logic [7:0] scsi_DATA_in;
    logic [7:0] scsi_DATA_out;
    logic       scsi_DATA_oe;
    logic       scsi_nACK;
    logic       scsi_nSEL;
    logic       scsi_nRST;

    modport slave (
        input  nFC40RD, nFC41RD, nFC40WR, nFC42WR, nFC43WR, nFC44WR, bbc_DATA_in,
        input  scsi_nBSY, scsi_nREQ, scsi_nMSG, scsi_nCD, scsi_nIO, scsi_DATA_in,
        output bbc_DATA_out, bbc_DATA_oe, nIRQ,
        output scsi_DATA_out, scsi_DATA_oe, scsi_nACK, scsi_nSEL, scsi_nRST
    );

    modport master (
        output nFC40RD, nFC41RD, nFC40WR, nFC42WR, nFC43WR, nFC44WR, bbc_DATA_in,
        output scsi_nBSY, scsi_nREQ, scsi_nMSG, scsi_nCD, scsi_nIO, scsi_DATA_in,
        input  bbc_DATA_out, bbc_DATA_oe, nIRQ,
        input  scsi_DATA_out, scsi_DATA_oe, scsi_nACK, scsi_nSEL, scsi_nRST
    );
endinterface

// File: rtl/host_adapter_bus_interface.sv
// Host adapter &FC40-&FC44 register stage with SCSI REQ/ACK handshake.
// Optional SEL timeout is built only when SCSI_SEL_TIMEOUT_EN is defined.
module host_adapter_bus_interface #(
    parameter int RST_PULSE_CYCLES   = 32
`ifdef SCSI_SEL_TIMEOUT_EN
    ,
    parameter int SEL_TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                          clock,
    input  logic                          reset,
    host_adapter_bus_interface_if.slave   bus
);

    localparam int N_ASYNC   = 11;
    localparam int N_STROBE  = 6;
    localparam int IDX_RD40  = 0;
    localparam int IDX_RD41  = 1;
    localparam int IDX_WR40  = 2;
    localparam int IDX_WR42  = 3;
    localparam int IDX_WR43  = 4;
    localparam int IDX_WR44  = 5;
    localparam int IDX_BSY   = 6;
    localparam int IDX_REQ   = 7;
    localparam int IDX_MSG   = 8;
    localparam int IDX_CD    = 9;
    localparam int IDX_IO    = 10;
    localparam int RST_CNT_W = $clog2(RST_PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_ACK_LOW  = 2'd2
    } hs_state_e;

    logic [N_ASYNC-1:0]  async_in;
    logic [N_ASYNC-1:0]  meta_q;
    logic [N_ASYNC-1:0]  sync_q;
    logic [N_STROBE-1:0] prev_q;
    logic [7:0]          bbc_meta_q;
    logic [7:0]          bbc_sync_q;
    logic [7:0]          scsi_meta_q;
    logic [7:0]          scsi_sync_q;

    assign async_in = {bus.scsi_nIO, bus.scsi_nCD, bus.scsi_nMSG, bus.scsi_nREQ,
                       bus.scsi_nBSY, bus.nFC44WR, bus.nFC43WR, bus.nFC42WR,
                       bus.nFC40WR, bus.nFC41RD, bus.nFC40RD};

    // Active-low lines idle high, so the synchronisers reset high to avoid a false edge.
    genvar gi;
    generate
        for (gi = 0; gi < N_ASYNC; gi++) begin : g_ctrl_sync
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_q[gi] <= 1'b1;
                    sync_q[gi] <= 1'b1;
                end else begin
                    meta_q[gi] <= async_in[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end

        for (gi = 0; gi < N_STROBE; gi++) begin : g_strobe_prev
            always_ff @(posedge clock) begin
                if (reset) begin
                    prev_q[gi] <= 1'b1;
                end else begin
                    prev_q[gi] <= sync_q[gi];
                end
            end
        end

        // Data buses share the strobe latency so a capture sees data from while the strobe was low.
        for (gi = 0; gi < 8; gi++) begin : g_data_sync
            always_ff @(posedge clock) begin
                if (reset) begin
                    bbc_meta_q[gi]  <= 1'b0;
                    bbc_sync_q[gi]  <= 1'b0;
                    scsi_meta_q[gi] <= 1'b0;
                    scsi_sync_q[gi] <= 1'b0;
                end else begin
                    bbc_meta_q[gi]  <= bus.bbc_DATA_in[gi];
                    bbc_sync_q[gi]  <= bbc_meta_q[gi];
                    scsi_meta_q[gi] <= bus.scsi_DATA_in[gi];
                    scsi_sync_q[gi] <= scsi_meta_q[gi];
                end
            end
        end
    endgenerate

    logic rd40_low, rd41_low, wr40_low, wr43_low;
    logic bsy_low, req_low, msg_low, cd_low, io_low;
    logic wr40_start, wr42_start, wr44_start;
    logic wr40_end, rd40_end, arm;

    assign rd40_low   = ~sync_q[IDX_RD40];
    assign rd41_low   = ~sync_q[IDX_RD41];
    assign wr40_low   = ~sync_q[IDX_WR40];
    assign wr43_low   = ~sync_q[IDX_WR43];
    assign bsy_low    = ~sync_q[IDX_BSY];
    assign req_low    = ~sync_q[IDX_REQ];
    assign msg_low    = ~sync_q[IDX_MSG];
    assign cd_low     = ~sync_q[IDX_CD];
    assign io_low     = ~sync_q[IDX_IO];

    assign wr40_start = prev_q[IDX_WR40] & ~sync_q[IDX_WR40];
    assign wr42_start = prev_q[IDX_WR42] & ~sync_q[IDX_WR42];
    assign wr44_start = prev_q[IDX_WR44] & ~sync_q[IDX_WR44];
    assign wr40_end   = ~prev_q[IDX_WR40] & sync_q[IDX_WR40];
    assign rd40_end   = ~prev_q[IDX_RD40] & sync_q[IDX_RD40];
    assign arm        = wr40_end | rd40_end;

    hs_state_e            state_q, state_d;
    logic [7:0]           scsi_data_q, scsi_data_d;
    logic                 scsi_oe_q, scsi_oe_d;
    logic [7:0]           bbc_data_q, bbc_data_d;
    logic                 bbc_oe_q, bbc_oe_d;
    logic                 irq_en_q, irq_en_d;
    logic                 nirq_q, nirq_d;
    logic                 nsel_q, nsel_d;
    logic                 nack_q, nack_d;
    logic                 nrst_q, nrst_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 irq_active;
    logic [7:0]           status_byte;
`ifdef SCSI_SEL_TIMEOUT_EN
    localparam int SEL_CNT_W = $clog2(SEL_TIMEOUT_CYCLES + 1);
    logic [SEL_CNT_W-1:0] sel_cnt_q, sel_cnt_d;
`endif

    assign irq_active  = irq_en_q & req_low;
    assign status_byte = {cd_low, io_low, req_low, irq_active, 2'b00, bsy_low, msg_low};

    // Handshake state machine; an &FC44 start overrides any arm in the same clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (arm)      state_d = ST_WAIT_REQ;
            ST_WAIT_REQ: if (req_low)  state_d = ST_ACK_LOW;
            ST_ACK_LOW:  if (!req_low) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
        if (wr44_start) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        scsi_data_d = scsi_data_q;
        scsi_oe_d   = scsi_oe_q;
        bbc_data_d  = bbc_data_q;
        bbc_oe_d    = rd40_low | rd41_low;
        irq_en_d    = irq_en_q;
        nirq_d      = ~irq_active;
        nsel_d      = nsel_q;
        rst_cnt_d   = rst_cnt_q;
        // ACK falls one clock after entering ACK_LOW and rises the clock the FSM leaves it.
        nack_d      = ~((state_q == ST_ACK_LOW) && (state_d == ST_ACK_LOW));
`ifdef SCSI_SEL_TIMEOUT_EN
        sel_cnt_d   = sel_cnt_q;
`endif

        if (wr40_low) begin
            scsi_data_d = bbc_sync_q;
        end
        if (wr44_start || io_low) begin
            scsi_oe_d = 1'b0;
        end else if (wr40_start) begin
            scsi_oe_d = 1'b1;
        end

        if (rd40_low) begin
            bbc_data_d = scsi_sync_q;
        end else if (rd41_low) begin
            bbc_data_d = status_byte;
        end

        if (wr44_start) begin
            irq_en_d = 1'b0;
        end else if (wr43_low) begin
            irq_en_d = bbc_sync_q[0];
        end

        // BSY seen in the same clock as the &FC42 start suppresses SEL entirely.
        if (wr44_start || bsy_low) begin
            nsel_d = 1'b1;
`ifdef SCSI_SEL_TIMEOUT_EN
            sel_cnt_d = '0;
`endif
        end else if (wr42_start) begin
            nsel_d = 1'b0;
`ifdef SCSI_SEL_TIMEOUT_EN
            sel_cnt_d = SEL_CNT_W'(SEL_TIMEOUT_CYCLES);
        end else if (!nsel_q && (sel_cnt_q != '0)) begin
            sel_cnt_d = sel_cnt_q - SEL_CNT_W'(1);
            if (sel_cnt_q == SEL_CNT_W'(1)) begin
                nsel_d = 1'b1;
            end
`endif
        end

        if (wr44_start) begin
            rst_cnt_d = RST_CNT_W'(RST_PULSE_CYCLES);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
        end
        nrst_d = (rst_cnt_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            scsi_data_q <= 8'h00;
            scsi_oe_q   <= 1'b0;
            bbc_data_q  <= 8'h00;
            bbc_oe_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            nirq_q      <= 1'b1;
            nsel_q      <= 1'b1;
            nack_q      <= 1'b1;
            nrst_q      <= 1'b1;
            rst_cnt_q   <= '0;
`ifdef SCSI_SEL_TIMEOUT_EN
            sel_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            scsi_data_q <= scsi_data_d;
            scsi_oe_q   <= scsi_oe_d;
            bbc_data_q  <= bbc_data_d;
            bbc_oe_q    <= bbc_oe_d;
            irq_en_q    <= irq_en_d;
            nirq_q      <= nirq_d;
            nsel_q      <= nsel_d;
            nack_q      <= nack_d;
            nrst_q      <= nrst_d;
            rst_cnt_q   <= rst_cnt_d;
`ifdef SCSI_SEL_TIMEOUT_EN
            sel_cnt_q   <= sel_cnt_d;
`endif
        end
    end

    assign bus.scsi_DATA_out = scsi_data_q;
    assign bus.scsi_DATA_oe  = scsi_oe_q;
    assign bus.bbc_DATA_out  = bbc_data_q;
    assign bus.bbc_DATA_oe   = bbc_oe_q;
    assign bus.nIRQ          = nirq_q;
    assign bus.scsi_nSEL     = nsel_q;
    assign bus.scsi_nACK     = nack_q;
    assign bus.scsi_nRST     = nrst_q;

endmodule

// File: tb/tb_host_adapter_bus_interface.sv
// Directed bench for host_adapter_bus_interface: cycle-exact checks sampled on the falling edge.
module tb_host_adapter_bus_interface;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    host_adapter_bus_interface_if bus_if ();

    host_adapter_bus_interface dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " nACK"},      bus_if.scsi_nACK,     1'b1);
        check({tag, " nSEL"},      bus_if.scsi_nSEL,     1'b1);
        check({tag, " nRST"},      bus_if.scsi_nRST,     1'b1);
        check({tag, " nIRQ"},      bus_if.nIRQ,          1'b1);
        check({tag, " scsi_data"}, bus_if.scsi_DATA_out, 8'h00);
        check({tag, " bbc_data"},  bus_if.bbc_DATA_out,  8'h00);
        check({tag, " scsi_oe"},   bus_if.scsi_DATA_oe,  1'b0);
        check({tag, " bbc_oe"},    bus_if.bbc_DATA_oe,   1'b0);
    endtask

    initial begin
        reset               = 1'b1;
        bus_if.nFC40RD      = 1'b1;
        bus_if.nFC41RD      = 1'b1;
        bus_if.nFC40WR      = 1'b1;
        bus_if.nFC42WR      = 1'b1;
        bus_if.nFC43WR      = 1'b1;
        bus_if.nFC44WR      = 1'b1;
        bus_if.bbc_DATA_in  = 8'h00;
        bus_if.scsi_nBSY    = 1'b1;
        bus_if.scsi_nREQ    = 1'b1;
        bus_if.scsi_nMSG    = 1'b1;
        bus_if.scsi_nCD     = 1'b1;
        bus_if.scsi_nIO     = 1'b1;
        bus_if.scsi_DATA_in = 8'h00;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // IRQ enable via &FC43, then REQ asserted
        bus_if.bbc_DATA_in = 8'h01;
        bus_if.nFC43WR = 1'b0;
        tick(4);
        bus_if.nFC43WR = 1'b1;
        tick(4);
        bus_if.scsi_nREQ = 1'b0;
        tick(2);
        check("irq not yet", bus_if.nIRQ, 1'b1);
        tick(1);
        check("irq asserted", bus_if.nIRQ, 1'b0);
        bus_if.nFC41RD = 1'b0;
        tick(2);
        check("fc41 oe early", bus_if.bbc_DATA_oe, 1'b0);
        tick(1);
        check("fc41 oe", bus_if.bbc_DATA_oe, 1'b1);
        check("fc41 status irq", bus_if.bbc_DATA_out, 8'h30);
        bus_if.nFC41RD = 1'b1;
        tick(3);
        check("fc41 oe drop", bus_if.bbc_DATA_oe, 1'b0);

        // &FC40 write A5, IO high, REQ low: drive bus then handshake
        bus_if.bbc_DATA_in = 8'hA5;
        bus_if.nFC40WR = 1'b0;
        tick(2);
        check("wr40 oe early", bus_if.scsi_DATA_oe, 1'b0);
        check("wr40 data early", bus_if.scsi_DATA_out, 8'h00);
        tick(1);
        check("wr40 oe", bus_if.scsi_DATA_oe, 1'b1);
        check("wr40 data", bus_if.scsi_DATA_out, 8'hA5);
        tick(1);
        bus_if.nFC40WR = 1'b1;
        tick(4);
        check("wr40 ack before", bus_if.scsi_nACK, 1'b1);
        tick(1);
        check("wr40 ack low", bus_if.scsi_nACK, 1'b0);
        bus_if.scsi_nREQ = 1'b1;
        tick(2);
        check("wr40 ack hold", bus_if.scsi_nACK, 1'b0);
        tick(1);
        check("wr40 ack release", bus_if.scsi_nACK, 1'b1);

        // IO low drops SCSI drive; &FC40 read returns SCSI data
        bus_if.scsi_nIO = 1'b0;
        bus_if.scsi_nREQ = 1'b0;
        bus_if.scsi_DATA_in = 8'h3C;
        tick(3);
        check("io low oe drop", bus_if.scsi_DATA_oe, 1'b0);
        bus_if.nFC40RD = 1'b0;
        tick(3);
        check("rd40 oe", bus_if.bbc_DATA_oe, 1'b1);
        check("rd40 data", bus_if.bbc_DATA_out, 8'h3C);
        bus_if.nFC40RD = 1'b1;
        tick(2);
        check("rd40 oe hold", bus_if.bbc_DATA_oe, 1'b1);
        tick(1);
        check("rd40 oe drop", bus_if.bbc_DATA_oe, 1'b0);
        tick(1);
        check("rd40 ack before", bus_if.scsi_nACK, 1'b1);
        tick(1);
        check("rd40 ack low", bus_if.scsi_nACK, 1'b0);
        bus_if.scsi_nREQ = 1'b1;
        tick(3);
        check("rd40 ack release", bus_if.scsi_nACK, 1'b1);
        tick(3);
        check("rd40 single ack", bus_if.scsi_nACK, 1'b1);

        // &FC42 selection answered by BSY
        bus_if.scsi_nIO = 1'b1;
        bus_if.nFC42WR = 1'b0;
        tick(2);
        check("sel early", bus_if.scsi_nSEL, 1'b1);
        tick(1);
        check("sel low", bus_if.scsi_nSEL, 1'b0);
        bus_if.nFC42WR = 1'b1;
        tick(7);
        bus_if.scsi_nBSY = 1'b0;
        tick(2);
        check("sel held", bus_if.scsi_nSEL, 1'b0);
        tick(1);
        check("sel released", bus_if.scsi_nSEL, 1'b1);
        bus_if.scsi_nBSY = 1'b1;
        tick(4);

        // BSY low together with the &FC42 strobe: no SEL
        bus_if.scsi_nBSY = 1'b0;
        bus_if.nFC42WR = 1'b0;
        tick(4);
        check("sel suppressed", bus_if.scsi_nSEL, 1'b1);
        bus_if.nFC42WR = 1'b1;
        bus_if.scsi_nBSY = 1'b1;
        tick(4);

        // &FC44 during ACK_LOW
        bus_if.scsi_nREQ = 1'b0;
        bus_if.nFC40RD = 1'b0;
        tick(3);
        bus_if.nFC40RD = 1'b1;
        tick(5);
        check("pre-rst ack low", bus_if.scsi_nACK, 1'b0);
        bus_if.nFC44WR = 1'b0;
        tick(2);
        check("rst early", bus_if.scsi_nRST, 1'b1);
        tick(1);
        check("rst low", bus_if.scsi_nRST, 1'b0);
        check("rst ack cleared", bus_if.scsi_nACK, 1'b1);
        bus_if.nFC44WR = 1'b1;
        tick(31);
        check("rst last low", bus_if.scsi_nRST, 1'b0);
        check("rst fsm idle", bus_if.scsi_nACK, 1'b1);
        tick(1);
        check("rst released", bus_if.scsi_nRST, 1'b1);
        check("rst irq disabled", bus_if.nIRQ, 1'b1);
        bus_if.nFC41RD = 1'b0;
        tick(3);
        check("rst status", bus_if.bbc_DATA_out, 8'h20);
        bus_if.nFC41RD = 1'b1;
        tick(3);

        // reset mid RST pulse with SEL, ACK and SCSI drive active
        bus_if.nFC44WR = 1'b0;
        tick(4);
        bus_if.nFC44WR = 1'b1;
        bus_if.bbc_DATA_in = 8'h5A;
        bus_if.nFC40WR = 1'b0;
        tick(4);
        bus_if.nFC40WR = 1'b1;
        bus_if.nFC42WR = 1'b0;
        tick(4);
        bus_if.nFC42WR = 1'b1;
        tick(4);
        check("pre-reset nRST", bus_if.scsi_nRST, 1'b0);
        check("pre-reset nSEL", bus_if.scsi_nSEL, 1'b0);
        check("pre-reset nACK", bus_if.scsi_nACK, 1'b0);
        check("pre-reset oe", bus_if.scsi_DATA_oe, 1'b1);
        check("pre-reset data", bus_if.scsi_DATA_out, 8'h5A);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
